fpu_result_wb: RTL and testbench

FPU_RESULT_WB -- requirements
Module: fpu_result_wb

---
 rtl/fpu_wb_pkg.sv | 28 ++
 rtl/fpu_fflags_acc.sv | 37 +++
 rtl/fpu_result_wb.sv | 151 +++++++++++++++
 tb/tb_fpu_result_wb.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_wb_pkg.sv
// Shared types for the FPU result writeback buffer.
// Entry fields are sized to the widest supported FLEN/XLEN.
package fpu_wb_pkg;

    localparam int FLEN_MAX = 64;
    localparam int XLEN_MAX = 64;

    localparam int FLG_NV = 4;
    localparam int FLG_DZ = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic [FLEN_MAX-1:0] res;
        logic [XLEN_MAX-1:0] intres;
        logic [4:0]          flg;
        logic                toint;
        logic [4:0]          rd;
    } wb_entry_t;

endpackage

// File: rtl/fpu_fflags_acc.sv
// Sticky fflags accumulator: ORs retired flags in, software write wins.
// Only instantiated when FPU_FFLAGS_ACCUM_EN is defined.
module fpu_fflags_acc
    import fpu_wb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       pop,
    input  logic [4:0] pop_flg,
    input  logic       csr_we,
    input  logic [4:0] csr_wdata,
    output logic [4:0] fflags
);

    logic [4:0] fflags_q;
    logic [4:0] fflags_d;

    always_comb begin
        fflags_d = fflags_q;
        if (csr_we) begin
            fflags_d = csr_wdata;
        end else if (pop) begin
            fflags_d = fflags_q | pop_flg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fflags_q <= '0;
        end else begin
            fflags_q <= fflags_d;
        end
    end

    assign fflags = fflags_q;

endmodule

// File: rtl/fpu_result_wb.sv
// Two-entry FPU result writeback FIFO with optional fflags accumulation.
// Define FPU_FFLAGS_ACCUM_EN to include the fflags accumulator.
module fpu_result_wb
    import fpu_wb_pkg::*;
#(
    parameter int FLEN = 64,
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FLEN-1:0] in_res,
    input  logic [XLEN-1:0] in_intres,
    input  logic [4:0]      in_flg,
    input  logic            in_toint,
    input  logic [4:0]      in_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FLEN-1:0] out_res,
    output logic [XLEN-1:0] out_intres,
    output logic [4:0]      out_flg,
    output logic            out_toint,
    output logic [4:0]      out_rd,
    input  logic            csr_we,
    input  logic [4:0]      csr_wdata,
    output logic [4:0]      fflags
);

    wb_state_e state_q, state_d;
    logic      wr_ptr_q, wr_ptr_d;
    logic      rd_ptr_q, rd_ptr_d;
    wb_entry_t mem_q [2];
    wb_entry_t mem_d [2];
    wb_entry_t in_entry;
    wb_entry_t head;
    logic      push;
    logic      pop;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (push) state_d = ONE;
            ONE: begin
                if (push && !pop) begin
                    state_d = TWO;
                end else if (pop && !push) begin
                    state_d = EMPTY;
                end
            end
            TWO: if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
    end

    // Handshake outputs depend on state only, never on out_ready.
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        unique case (state_q)
            EMPTY: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
            ONE: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
            end
            TWO: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end
    end

    always_comb begin
        in_entry.res    = FLEN_MAX'(in_res);
        in_entry.intres = XLEN_MAX'(in_intres);
        in_entry.flg    = in_flg;
        in_entry.toint  = in_toint;
        in_entry.rd     = in_rd;
    end

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_entry;
        end
    end

    // Payload storage carries no reset; it is only observed behind out_valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head       = mem_q[rd_ptr_q];
    assign out_res    = FLEN'(head.res);
    assign out_intres = XLEN'(head.intres);
    assign out_flg    = head.flg;
    assign out_toint  = head.toint;
    assign out_rd     = head.rd;

`ifdef FPU_FFLAGS_ACCUM_EN
    fpu_fflags_acc u_fflags_acc (
        .clk       (clk),
        .reset     (reset),
        .pop       (pop),
        .pop_flg   (head.flg),
        .csr_we    (csr_we),
        .csr_wdata (csr_wdata),
        .fflags    (fflags)
    );
`else
    logic unused_csr;
    assign unused_csr = ^{csr_we, csr_wdata};
    assign fflags     = '0;
`endif

endmodule

// File: tb/tb_fpu_result_wb.sv
// Directed self-checking bench for fpu_result_wb.
// fflags expectations follow FPU_FFLAGS_ACCUM_EN.
module tb_fpu_result_wb;

    localparam int FLEN = 64;
    localparam int XLEN = 64;

`ifdef FPU_FFLAGS_ACCUM_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [FLEN-1:0] in_res;
    logic [XLEN-1:0] in_intres;
    logic [4:0]      in_flg;
    logic            in_toint;
    logic [4:0]      in_rd;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [FLEN-1:0] out_res;
    logic [XLEN-1:0] out_intres;
    logic [4:0]      out_flg;
    logic            out_toint;
    logic [4:0]      out_rd;
    logic            csr_we;
    logic [4:0]      csr_wdata;
    logic [4:0]      fflags;

    int checks = 0;
    int errors = 0;

    fpu_result_wb #(.FLEN(FLEN), .XLEN(XLEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_res     (in_res),
        .in_intres  (in_intres),
        .in_flg     (in_flg),
        .in_toint   (in_toint),
        .in_rd      (in_rd),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .out_intres (out_intres),
        .out_flg    (out_flg),
        .out_toint  (out_toint),
        .out_rd     (out_rd),
        .csr_we     (csr_we),
        .csr_wdata  (csr_wdata),
        .fflags     (fflags)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] ef(input logic [4:0] v);
        return ACC ? v : 5'd0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] res, input logic [4:0] flg,
                         input logic [4:0] rd, input logic toint);
        in_valid  = 1'b1;
        in_res    = res;
        in_intres = res ^ 64'h5555_0000_0000_AAAA;
        in_flg    = flg;
        in_rd     = rd;
        in_toint  = toint;
    endtask

    initial begin
        clk       = 1'b0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_res    = '0;
        in_intres = '0;
        in_flg    = '0;
        in_toint  = 1'b0;
        in_rd     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        csr_we    = 1'b0;
        csr_wdata = '0;

        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_fflags", 64'(fflags), 64'd0);
        reset = 1'b0;

        // single push, one-cycle latency, flag accumulate
        out_ready = 1'b1;
        drive(64'h3FF0_0000_0000_0000, 5'b00001, 5'd3, 1'b0);
        tick();
        in_valid = 1'b0;
        check("lat_valid", 64'(out_valid), 64'd1);
        check("lat_res", out_res, 64'h3FF0_0000_0000_0000);
        check("lat_intres", out_intres, 64'h6AA5_0000_0000_AAAA);
        check("lat_flg", 64'(out_flg), 64'd1);
        check("lat_rd", 64'(out_rd), 64'd3);
        check("lat_fflags_pre", 64'(fflags), 64'd0);
        tick();
        check("pop_valid", 64'(out_valid), 64'd0);
        check("pop_fflags", 64'(fflags), 64'(ef(5'b00001)));
        csr_we    = 1'b1;
        csr_wdata = 5'd0;
        tick();
        csr_we = 1'b0;
        check("clr_fflags", 64'(fflags), 64'd0);

        // fill to TWO, third push ignored, drain in order
        out_ready = 1'b0;
        drive(64'hA, 5'd0, 5'd1, 1'b0);
        tick();
        drive(64'hB, 5'd0, 5'd2, 1'b1);
        tick();
        check("two_in_ready", 64'(in_ready), 64'd0);
        check("two_out_valid", 64'(out_valid), 64'd1);
        drive(64'hC, 5'd0, 5'd7, 1'b0);
        tick();
        in_valid = 1'b0;
        check("stall_res", out_res, 64'hA);
        check("stall_rd", 64'(out_rd), 64'd1);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        check("drain_b_valid", 64'(out_valid), 64'd1);
        check("drain_b_res", out_res, 64'hB);
        check("drain_b_toint", 64'(out_toint), 64'd1);
        tick();
        check("drain_empty", 64'(out_valid), 64'd0);
        tick();
        check("no_c", 64'(out_valid), 64'd0);

        // steady push+pop in ONE for 8 cycles
        drive(64'h1000, 5'd0, 5'd0, 1'b0);
        tick();
        for (int i = 1; i <= 8; i++) begin
            check("pp_res", out_res, 64'h1000 + 64'(i - 1));
            check("pp_rd", 64'(out_rd), 64'(i - 1));
            drive(64'h1000 + 64'(i), 5'd0, 5'(i), 1'(i));
            tick();
            check("pp_in_ready", 64'(in_ready), 64'd1);
            check("pp_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        check("pp_last_res", out_res, 64'h1008);
        check("pp_last_toint", 64'(out_toint), 64'd0);
        tick();
        check("pp_drained", 64'(out_valid), 64'd0);

        // flush from TWO drops held and incoming entries
        out_ready = 1'b0;
        drive(64'h41, 5'd0, 5'd4, 1'b0);
        tick();
        drive(64'h42, 5'd0, 5'd5, 1'b0);
        tick();
        check("fl_full", 64'(in_ready), 64'd0);
        flush = 1'b1;
        drive(64'h43, 5'd0, 5'd6, 1'b0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_in_ready", 64'(in_ready), 64'd1);
        tick();
        check("fl_dropped", 64'(out_valid), 64'd0);
        drive(64'h44, 5'd0, 5'd8, 1'b0);
        tick();
        in_valid = 1'b0;
        check("fl_after_res", out_res, 64'h44);
        out_ready = 1'b1;
        tick();
        check("fl_after_pop", 64'(out_valid), 64'd0);

        // csr write wins over same-cycle pop flags
        csr_we    = 1'b1;
        csr_wdata = 5'b00100;
        tick();
        csr_we = 1'b0;
        check("csr_set", 64'(fflags), 64'(ef(5'b00100)));
        out_ready = 1'b0;
        drive(64'h50, 5'b10000, 5'd9, 1'b0);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        csr_we    = 1'b1;
        csr_wdata = 5'd0;
        tick();
        csr_we = 1'b0;
        check("csr_prio", 64'(fflags), 64'd0);
        check("csr_pop", 64'(out_valid), 64'd0);

        // pop alongside flush still retires its flags
        out_ready = 1'b0;
        drive(64'h60, 5'b01000, 5'd10, 1'b0);
        tick();
        in_valid  = 1'b0;
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        check("flpop_fflags", 64'(fflags), 64'(ef(5'b01000)));
        check("flpop_valid", 64'(out_valid), 64'd0);
        drive(64'h61, 5'b00010, 5'd11, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        check("acc_or", 64'(fflags), 64'(ef(5'b01010)));

        // reset in TWO with out_ready high
        out_ready = 1'b0;
        drive(64'h70, 5'b00001, 5'd12, 1'b0);
        tick();
        drive(64'h71, 5'b00001, 5'd13, 1'b0);
        tick();
        in_valid = 1'b0;
        check("rs_full", 64'(in_ready), 64'd0);
        reset     = 1'b1;
        out_ready = 1'b1;
        tick();
        reset = 1'b0;
        check("rs_valid", 64'(out_valid), 64'd0);
        check("rs_in_ready", 64'(in_ready), 64'd1);
        check("rs_fflags", 64'(fflags), 64'd0);
        drive(64'h80, 5'd0, 5'd14, 1'b0);
        tick();
        in_valid = 1'b0;
        check("rs_after_res", out_res, 64'h80);
        tick();
        check("rs_after_pop", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
